// File: rtl/div_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_ctrl : RV64M DIV/REM sequencer in front of the iterative 64-bit divider
// Revision : 1.0
// ----------------------------------------------------------------------------
module div_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_w,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             dv_id_valid,
  output logic             dv_div_ena,
  output logic             dv_signed,
  output logic             dv_w,
  output logic [XLEN-1:0]  dv_dividend,
  output logic [XLEN-1:0]  dv_divisor,
  output logic             dv_ex_ready,
  input  logic             dv_valid,
  input  logic [XLEN-1:0]  dv_quotient,
  input  logic [XLEN-1:0]  dv_remainder
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_CACHE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state, w_state_nxt, w_launch;
  logic [1:0]         r_op;
  logic               r_w;
  logic [XLEN-1:0]    r_src1, r_src2, r_res;
  logic [TAG_W-1:0]   r_tag;
  logic               r_cache_valid, r_ck_signed, r_ck_w;
  logic [XLEN-1:0]    r_ck_src1, r_ck_src2, r_ck_q, r_ck_r;

  logic               w_accept, w_req_special, w_req_hit, w_busy, w_dz;
  logic [XLEN-1:0]    w_dend, w_spec_res, w_dv_q, w_dv_res, w_cache_res;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic div_zero(input logic [XLEN-1:0] b, input logic w);
    return w ? (b[31:0] == 32'd0) : (b == '0);
  endfunction

  function automatic logic sgn_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic sgn, input logic w);
    return sgn & (w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                    : ((a == C_INT_MIN) && (b == '1)));
  endfunction

  assign w_accept      = req_valid & req_ready;
  assign w_req_special = div_zero(req_src2, req_w) | sgn_ovf(req_src1, req_src2, ~req_op[0], req_w);
  // A flush on the accept cycle invalidates the cache, so it must not hit either.
  assign w_req_hit     = r_cache_valid & ~flush & (req_src1 == r_ck_src1) & (req_src2 == r_ck_src2)
                       & (~req_op[0] == r_ck_signed) & (req_w == r_ck_w);
  assign w_launch      = w_req_special ? S_SPECIAL : (w_req_hit ? S_CACHE : S_ISSUE);
  assign w_busy        = (r_state == S_ISSUE) | (r_state == S_WAIT) | (r_state == S_DRAIN);

  assign w_dz          = div_zero(r_src2, r_w);
  assign w_dend        = r_w ? sext32(r_src1) : r_src1;
  assign w_spec_res    = r_op[1] ? (w_dz ? w_dend : '0) : (w_dz ? '1 : w_dend);
  assign w_dv_q        = r_w ? sext32(dv_quotient) : dv_quotient;
  assign w_dv_res      = r_op[1] ? dv_remainder : w_dv_q;
  assign w_cache_res   = r_op[1] ? r_ck_r : r_ck_q;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = w_launch;
      S_SPECIAL,
      S_CACHE:   w_state_nxt = flush ? S_IDLE : S_RESP;
      S_ISSUE:   if (flush) w_state_nxt = dv_valid ? S_IDLE : S_DRAIN;
                 else if (!dv_valid) w_state_nxt = S_WAIT;
      S_WAIT:    if (flush) w_state_nxt = dv_valid ? S_IDLE : S_DRAIN;
                 else if (dv_valid) w_state_nxt = S_RESP;
      S_RESP:    if (flush) w_state_nxt = S_IDLE;
                 else if (resp_ready) w_state_nxt = w_accept ? w_launch : S_IDLE;
      S_DRAIN:   if (dv_valid) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_w           <= 1'b0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_tag         <= '0;
      r_res         <= '0;
      r_cache_valid <= 1'b0;
      r_ck_signed   <= 1'b0;
      r_ck_w        <= 1'b0;
      r_ck_src1     <= '0;
      r_ck_src2     <= '0;
      r_ck_q        <= '0;
      r_ck_r        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= req_op;
        r_w    <= req_w;
        r_src1 <= req_src1;
        r_src2 <= req_src2;
        r_tag  <= req_tag;
      end
      case (r_state)
        S_SPECIAL: r_res <= w_spec_res;
        S_CACHE:   r_res <= w_cache_res;
        S_WAIT:    if (dv_valid) r_res <= w_dv_res;
        default:   ;
      endcase
      if (flush) begin
        r_cache_valid <= 1'b0;
      end else if ((r_state == S_WAIT) && dv_valid) begin
        r_cache_valid <= 1'b1;
        r_ck_src1     <= r_src1;
        r_ck_src2     <= r_src2;
        r_ck_signed   <= ~r_op[0];
        r_ck_w        <= r_w;
        r_ck_q        <= w_dv_q;
        r_ck_r        <= dv_remainder;
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE) | ((r_state == S_RESP) & resp_ready & ~flush);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_data   = r_res;
  assign resp_tag    = r_tag;
  assign dv_id_valid = (r_state == S_ISSUE) & ~dv_valid;
  assign dv_div_ena  = dv_id_valid;
  assign dv_signed   = w_busy & ~r_op[0];
  assign dv_w        = w_busy & r_w;
  assign dv_dividend = w_busy ? r_src1 : '0;
  assign dv_divisor  = w_busy ? r_src2 : '0;
  assign dv_ex_ready = ((r_state == S_WAIT) | (r_state == S_DRAIN)) & dv_valid;

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 64-bit divider.
- Accepts RV64M divide/remainder requests (DIV/DIVU/REM/REMU and the W forms) over a valid/ready handshake and launches the divider with its one-cycle start pulse.
- Resolves divide-by-zero and signed overflow without using the divider, and reuses the previous quotient/remainder when a DIV/REM pair has identical operands.
- Returns one sign-correct XLEN result per request and tolerates a flush at any point.

Parameters:
- XLEN, 64, operand and result width; only 64 is supported.
- TAG_W, 5, width of the destination tag carried with each request.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  bit1: 1 = REM, 0 = DIV. bit0: 1 = unsigned, 0 = signed.
- req_w  in  1  32-bit (W) operation.
- req_src1  in  XLEN  dividend.
- req_src2  in  XLEN  divisor.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  discard the in-flight request.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  result.
- resp_tag  out  TAG_W  tag of the result.
- dv_id_valid  out  1  divider start qualifier.
- dv_div_ena  out  1  divider enable.
- dv_signed  out  1  signed division.
- dv_w  out  1  divider word mode.
- dv_dividend  out  XLEN  divider dividend.
- dv_divisor  out  XLEN  divider divisor.
- dv_ex_ready  out  1  release the divider result.
- dv_valid  in  1  divider result valid.
- dv_quotient  in  XLEN  divider quotient.
- dv_remainder  in  XLEN  divider remainder.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - state = IDLE; cache invalid.
  - All outputs 0 except req_ready = 1.
  - A reset while the divider is mid-operation is legal; the divider is reset by the same signal.
- Request registers: on acceptance (req_valid & req_ready), latch op, w, src1, src2 and tag.
- req_ready: 1 only in IDLE, or in RESP in the same cycle that resp_ready = 1.
- States and transitions:
  - IDLE → SPECIAL on accept when either special case holds:
    - Divisor is zero. For W, test src2[31:0] == 0.
    - Signed overflow (signed op only): src1 = 0x8000_0000_0000_0000 and src2 = all ones. For W, src1[31:0] = 0x8000_0000 and src2[31:0] = 0xFFFF_FFFF.
  - IDLE → CACHE on accept when the cache is valid and {src1, src2, signed, w} matches the cached key.
  - IDLE → ISSUE on accept otherwise.
  - SPECIAL and CACHE: compute the result in one cycle, then go to RESP.
  - ISSUE: assert dv_id_valid = dv_div_ena = 1 for exactly one cycle. dv_signed, dv_w, dv_dividend and dv_divisor hold the latched values from ISSUE until the result is released. Then go to WAIT.
  - WAIT: wait on dv_valid; there is no fixed latency assumption. On dv_valid = 1:
    - capture quotient and remainder;
    - write the cache key and both results, and set the cache valid;
    - assert dv_ex_ready for that single cycle, then go to RESP.
  - RESP: hold resp_valid = 1 with stable data and tag until resp_ready = 1, then go to IDLE, or take a new request in the same cycle.
- Divide-by-zero results (RISC-V):
  - Quotient = all ones.
  - Remainder = dividend; for W, sign-extend src1[31:0].
- Signed-overflow results:
  - Quotient = dividend; for W, sign-extend src1[31:0].
  - Remainder = 0.
- W results: the divider returns a zero-extended W quotient, so the controller sign-extends bit 31 of the quotient. The W remainder passes through unchanged.
- Result select: req_op[1] chooses the remainder, otherwise the quotient.
- Flush:
  - In SPECIAL, CACHE or RESP: go to IDLE next cycle, resp_valid = 0.
  - In ISSUE or WAIT: go to DRAIN. The divider cannot abort, so DRAIN waits for dv_valid, pulses dv_ex_ready, does not update the cache and produces no response, then goes to IDLE.
  - Flush in IDLE is ignored.
- Cache valid is cleared by reset and by any flush. Cache hits do not touch the divider.
- Simultaneous flush and resp_ready: flush wins and the response is dropped.
- dv_id_valid is never high unless dv_valid = 0.

Test Plan:
- DIV signed, src1 = -20, src2 = 3 → resp_data = -6 (0xFFFF_FFFF_FFFF_FFFA); exactly one dv_id_valid pulse; dv_ex_ready pulses once at dv_valid.
- REMU, src1 = 7, src2 = 0 → resp_data = 7, visible 2 cycles after accept, dv_id_valid never asserted. DIVUW with src2 = 0 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW, src1 = 0x8000_0000, src2 = 0xFFFF_FFFF → resp_data = 0xFFFF_FFFF_8000_0000. REMW with the same operands → 0.
- DIVW, src1 = -9, src2 = 2 → 0xFFFF_FFFF_FFFF_FFFC. Then REMW with the same operands → 0xFFFF_FFFF_FFFF_FFFF from the cache, with no divider start.
- Flush 5 cycles after ISSUE → no resp_valid; controller stays in DRAIN until dv_valid, pulses dv_ex_ready once; the next request (DIVU 100/7) returns 14 correctly and does not hit the cache.
- Hold resp_ready = 0 for 10 cycles → resp_data and resp_tag stable and req_ready = 0 throughout. Assert reset mid-WAIT → all outputs return to reset values next cycle.
